// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access format codes,
// responder FSM states and the latency counter width.
package dmem_pkg;

  localparam logic [1:0] FMT_BYTE = 2'b00;
  localparam logic [1:0] FMT_HALF = 2'b01;
  localparam logic [1:0] FMT_WORD = 2'b10;
  localparam logic [1:0] FMT_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store byte enables and replicated store
// data, right-aligned zero-extended load data, and the alignment check.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  i_format,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misalign
);

  always_comb begin
    o_be       = 4'b0000;
    o_wdata    = '0;
    o_rdata    = '0;
    o_misalign = 1'b0;
    case (i_format)
      FMT_BYTE: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {24'b0, i_rword[{i_addr_lo, 3'b000} +: 8]};
      end
      FMT_HALF: begin
        o_misalign = i_addr_lo[0];
        o_be       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata    = {2{i_wdata[15:0]}};
        o_rdata    = {16'b0, i_rword[{i_addr_lo[1], 4'b0000} +: 16]};
      end
      FMT_WORD: begin
        o_misalign = |i_addr_lo;
        o_be       = 4'b1111;
        o_wdata    = i_wdata;
        o_rdata    = i_rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Slave end of the core load/store port: one request at a time, fixed
// LATENCY from accept to response, byte-masked word RAM behind it.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_format,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int               WORDS    = 2 ** (ADDR_WIDTH - 2);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_we;
  logic [1:0]            r_fmt;
  logic [31:0]           r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_rdata;
  logic                  r_err;
  logic [31:0]           r_mem [WORDS];

  logic                  w_accept;
  logic                  w_enter_resp;
  logic                  w_we;
  logic [1:0]            w_fmt;
  logic [31:0]           w_addr;
  logic [31:0]           w_wdata;
  logic [ADDR_WIDTH-3:0] w_idx;
  logic [31:0]           w_rword;
  logic [3:0]            w_be;
  logic [31:0]           w_sdata;
  logic [31:0]           w_ldata;
  logic                  w_misalign;
  logic                  w_oob;
  logic                  w_err;

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = (r_state == RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

  assign w_accept = req_valid && (r_state == IDLE);

  // With LATENCY==1 the access happens on the accept edge itself, so it must
  // see the live request rather than the latches.
  assign w_enter_resp = (LATENCY == 1) ? w_accept
                                       : ((r_state == WAIT) && (r_cnt == CNT_W'(1)));
  assign w_we    = (LATENCY == 1) ? req_we     : r_we;
  assign w_fmt   = (LATENCY == 1) ? req_format : r_fmt;
  assign w_addr  = (LATENCY == 1) ? req_addr   : r_addr;
  assign w_wdata = (LATENCY == 1) ? req_wdata  : r_wdata;

  assign w_idx   = w_addr[ADDR_WIDTH-1:2];
  assign w_rword = r_mem[w_idx];
  assign w_oob   = |(w_addr >> ADDR_WIDTH);
  assign w_err   = (w_fmt == FMT_ILL) || w_misalign || w_oob;

  dmem_lane_align u_align (
    .i_format   (w_fmt),
    .i_addr_lo  (w_addr[1:0]),
    .i_wdata    (w_wdata),
    .i_rword    (w_rword),
    .o_be       (w_be),
    .o_wdata    (w_sdata),
    .o_rdata    (w_ldata),
    .o_misalign (w_misalign)
  );

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we    <= req_we;
      r_fmt   <= req_format;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end
  end

  // Reset on the access edge must suppress the write, hence the !rst term.
  always_ff @(posedge clk) begin
    if (!rst && w_enter_resp && w_we && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_sdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_cnt   <= CNT_LOAD;
            r_state <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_state <= RESP;
        end
        RESP: begin
          if (resp_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      if (w_enter_resp) begin
        r_err   <= w_err;
        r_rdata <= (w_we || w_err) ? 32'h0 : w_ldata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 1, 2, 3) share the
// request bus; sel routes req_valid to one and picks its outputs.
module tb_dmem_responder;
  import dmem_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic        we;
    logic [1:0]  fmt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] erd;
    logic        eerr;
  } op_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_format;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_ready;
  logic [1:0]  sel;
  logic [2:0]  rv, rdy, vld, errs_o;
  logic [31:0] rd [3];

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_acc = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rv[0] = req_valid && (sel == 2'd0);
  assign rv[1] = req_valid && (sel == 2'd1);
  assign rv[2] = req_valid && (sel == 2'd2);

  dmem_responder #(.ADDR_WIDTH(16), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(rdy[0]), .req_we(req_we),
    .req_format(req_format), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(vld[0]), .resp_ready(resp_ready), .resp_rdata(rd[0]), .resp_err(errs_o[0]));
  dmem_responder #(.ADDR_WIDTH(16), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(rdy[1]), .req_we(req_we),
    .req_format(req_format), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(vld[1]), .resp_ready(resp_ready), .resp_rdata(rd[1]), .resp_err(errs_o[1]));
  dmem_responder #(.ADDR_WIDTH(16), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .req_valid(rv[2]), .req_ready(rdy[2]), .req_we(req_we),
    .req_format(req_format), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(vld[2]), .resp_ready(resp_ready), .resp_rdata(rd[2]), .resp_err(errs_o[2]));

  // Starts and ends at a falling edge; last_acc is the cycle count seen in
  // the first cycle after the accept edge.
  task automatic send(input logic we, input logic [1:0] fmt, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] erd, input logic eerr,
                      output bit to);
    int k = 0;
    to = 1'b0;
    req_we = we; req_format = fmt; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    while (rdy[sel] !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) begin to = 1'b1; req_valid = 1'b0; return; end
    @(posedge clk);
    @(negedge clk);
    last_acc  = cyc;
    req_valid = 1'b0;
    sb.push_back('{erd, eerr});
  endtask

  // lat counts cycles after the accept edge: 1 means visible right after it.
  task automatic recv(output logic [31:0] d, output logic e, output int lat, output bit to);
    int k = 0;
    to = 1'b0;
    resp_ready = 1'b1;
    while (vld[sel] !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) to = 1'b1;
    lat = cyc - last_acc + 1;
    d = rd[sel];
    e = errs_o[sel];
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b1;
    req_we = 1'b0; req_format = FMT_WORD; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rdy[i] !== 1'b1 || vld[i] !== 1'b0 || rd[i] !== 32'h0 || errs_o[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset[%0d] got rdy=%b vld=%b rdata=%h err=%b want 1 0 00000000 0",
                 i, rdy[i], vld[i], rd[i], errs_o[i]);
      end
    end
  endtask

  task automatic test_word();
    op_t ops[2] = '{'{1'b1, FMT_WORD, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0},
                    '{1'b0, FMT_WORD, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0}};
    logic [31:0] d; logic e; int lat; bit to; exp_t ex;
    foreach (ops[i]) begin
      send(ops[i].we, ops[i].fmt, ops[i].addr, ops[i].wdata, ops[i].erd, ops[i].eerr, to);
      checks++;
      if (to) begin errors++; $display("FAIL word[%0d] accept timed out", i); continue; end
      recv(d, e, lat, to);
      ex = sb.pop_front();
      if (to || d !== ex.rdata || e !== ex.err) begin
        errors++;
        $display("FAIL word[%0d] got rdata=%h err=%b want rdata=%h err=%b", i, d, e, ex.rdata, ex.err);
      end
      checks++;
      if (lat != 2) begin errors++; $display("FAIL word[%0d] latency got %0d want 2", i, lat); end
    end
  endtask

  task automatic test_lanes();
    op_t ops[9] = '{'{1'b1, FMT_WORD, 32'h200, 32'h00000000, 32'h0, 1'b0},
                    '{1'b1, FMT_BYTE, 32'h202, 32'hFFFFFFAB, 32'h0, 1'b0},
                    '{1'b1, FMT_HALF, 32'h200, 32'hCAFE1234, 32'h0, 1'b0},
                    '{1'b0, FMT_WORD, 32'h200, 32'h0, 32'h00AB1234, 1'b0},
                    '{1'b0, FMT_BYTE, 32'h202, 32'h0, 32'h000000AB, 1'b0},
                    '{1'b0, FMT_HALF, 32'h202, 32'h0, 32'h000000AB, 1'b0},
                    '{1'b0, FMT_BYTE, 32'h201, 32'h0, 32'h00000012, 1'b0},
                    '{1'b0, FMT_BYTE, 32'h203, 32'h0, 32'h00000000, 1'b0},
                    '{1'b0, FMT_HALF, 32'h200, 32'h0, 32'h00001234, 1'b0}};
    logic [31:0] d; logic e; int lat; bit to; exp_t ex;
    foreach (ops[i]) begin
      send(ops[i].we, ops[i].fmt, ops[i].addr, ops[i].wdata, ops[i].erd, ops[i].eerr, to);
      checks++;
      if (to) begin errors++; $display("FAIL lanes[%0d] accept timed out", i); continue; end
      recv(d, e, lat, to);
      ex = sb.pop_front();
      if (to || d !== ex.rdata || e !== ex.err) begin
        errors++;
        $display("FAIL lanes[%0d] got rdata=%h err=%b want rdata=%h err=%b", i, d, e, ex.rdata, ex.err);
      end
    end
  endtask

  task automatic test_errors();
    op_t ops[9] = '{'{1'b1, FMT_WORD, 32'h101, 32'h12345678, 32'h0, 1'b1},
                    '{1'b0, FMT_WORD, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0},
                    '{1'b0, FMT_HALF, 32'h103, 32'h0, 32'h0, 1'b1},
                    '{1'b0, FMT_ILL,  32'h100, 32'h0, 32'h0, 1'b1},
                    '{1'b0, FMT_WORD, 32'h00010000, 32'h0, 32'h0, 1'b1},
                    '{1'b1, FMT_BYTE, 32'h00010101, 32'h77, 32'h0, 1'b1},
                    '{1'b1, FMT_ILL,  32'h100, 32'h0, 32'h0, 1'b1},
                    '{1'b1, FMT_HALF, 32'h102, 32'h0000AAAA, 32'h0, 1'b0},
                    '{1'b0, FMT_WORD, 32'h100, 32'h0, 32'hAAAABEEF, 1'b0}};
    logic [31:0] d; logic e; int lat; bit to; exp_t ex;
    foreach (ops[i]) begin
      send(ops[i].we, ops[i].fmt, ops[i].addr, ops[i].wdata, ops[i].erd, ops[i].eerr, to);
      checks++;
      if (to) begin errors++; $display("FAIL errs[%0d] accept timed out", i); continue; end
      recv(d, e, lat, to);
      ex = sb.pop_front();
      if (to || d !== ex.rdata || e !== ex.err) begin
        errors++;
        $display("FAIL errs[%0d] got rdata=%h err=%b want rdata=%h err=%b", i, d, e, ex.rdata, ex.err);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d; logic e; int lat; bit to; exp_t ex; int k = 0;
    resp_ready = 1'b0;
    send(1'b0, FMT_WORD, 32'h200, 32'h0, 32'h00AB1234, 1'b0, to);
    while (vld[sel] !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    ex = sb.pop_front();
    checks++;
    if (to || k >= 50) begin
      errors++; $display("FAIL bp_first response timed out"); resp_ready = 1'b1; return;
    end
    req_we = 1'b0; req_format = FMT_BYTE; req_addr = 32'h202; req_wdata = '0; req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (vld[sel] !== 1'b1 || rd[sel] !== ex.rdata || errs_o[sel] !== ex.err || rdy[sel] !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d] got vld=%b rdata=%h err=%b rdy=%b want 1 %h %b 0",
                 c, vld[sel], rd[sel], errs_o[sel], rdy[sel], ex.rdata, ex.err);
      end
    end
    resp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (rdy[sel] !== 1'b1 || vld[sel] !== 1'b0) begin
      errors++; $display("FAIL bp_release got rdy=%b vld=%b want 1 0", rdy[sel], vld[sel]);
    end
    @(negedge clk);
    last_acc = cyc; req_valid = 1'b0;
    sb.push_back('{32'h000000AB, 1'b0});
    checks++;
    if (rdy[sel] !== 1'b0) begin errors++; $display("FAIL bp_accept got rdy=%b want 0", rdy[sel]); end
    recv(d, e, lat, to);
    ex = sb.pop_front();
    checks++;
    if (to || d !== ex.rdata || e !== ex.err || lat != 2) begin
      errors++;
      $display("FAIL bp_second got rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=2",
               d, e, lat, ex.rdata, ex.err);
    end
  endtask

  task automatic test_reset_wait();
    op_t ops[2] = '{'{1'b1, FMT_BYTE, 32'h10, 32'h11, 32'h0, 1'b0},
                    '{1'b0, FMT_BYTE, 32'h10, 32'h0, 32'h11, 1'b0}};
    logic [31:0] d; logic e; int lat; bit to; exp_t ex;
    foreach (ops[i]) begin
      send(ops[i].we, ops[i].fmt, ops[i].addr, ops[i].wdata, ops[i].erd, ops[i].eerr, to);
      checks++;
      if (to) begin errors++; $display("FAIL rstw_pre[%0d] accept timed out", i); continue; end
      recv(d, e, lat, to);
      ex = sb.pop_front();
      if (to || d !== ex.rdata || e !== ex.err || lat != 3) begin
        errors++;
        $display("FAIL rstw_pre[%0d] got rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=3",
                 i, d, e, lat, ex.rdata, ex.err);
      end
    end
    // delay 0: reset in WAIT; delay 1: reset on the edge that would enter RESP
    for (int dly = 0; dly < 2; dly++) begin
      send(1'b1, FMT_BYTE, 32'h10, 32'h55 + dly, 32'h0, 1'b0, to);
      if (!to) void'(sb.pop_front());
      repeat (dly) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (to || rdy[sel] !== 1'b1 || vld[sel] !== 1'b0 || rd[sel] !== 32'h0 || errs_o[sel] !== 1'b0) begin
        errors++;
        $display("FAIL rstw_out[%0d] got rdy=%b vld=%b rdata=%h err=%b want 1 0 00000000 0",
                 dly, rdy[sel], vld[sel], rd[sel], errs_o[sel]);
      end
      send(1'b0, FMT_BYTE, 32'h10, 32'h0, 32'h11, 1'b0, to);
      checks++;
      if (to) begin errors++; $display("FAIL rstw_load[%0d] accept timed out", dly); continue; end
      recv(d, e, lat, to);
      ex = sb.pop_front();
      if (to || d !== ex.rdata || e !== ex.err) begin
        errors++;
        $display("FAIL rstw_load[%0d] got rdata=%h err=%b want rdata=%h err=%b", dly, d, e, ex.rdata, ex.err);
      end
    end
  endtask

  task automatic test_lat1();
    logic [31:0] d; logic e; int lat; bit to; exp_t ex; int prev = 0;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a, v;
      a = 32'h40 + 32'(i / 2) * 8;
      v = 32'hA5000000 + 32'(i * 3);
      if (i % 2 == 0) send(1'b1, FMT_WORD, a, v, 32'h0, 1'b0, to);
      else            send(1'b0, FMT_WORD, a, 32'h0, 32'hA5000000 + 32'((i - 1) * 3), 1'b0, to);
      checks++;
      if (to) begin errors++; $display("FAIL lat1[%0d] accept timed out", i); continue; end
      if (i > 0 && last_acc - prev != 2) begin
        errors++; $display("FAIL lat1[%0d] accept spacing got %0d want 2", i, last_acc - prev);
      end
      prev = last_acc;
      recv(d, e, lat, to);
      ex = sb.pop_front();
      checks++;
      if (to || d !== ex.rdata || e !== ex.err || lat != 1) begin
        errors++;
        $display("FAIL lat1[%0d] got rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=1",
                 i, d, e, lat, ex.rdata, ex.err);
      end
    end
  endtask

  initial begin
    sel = 2'd1;
    test_reset();
    test_word();
    test_lanes();
    test_errors();
    test_backpressure();
    sel = 2'd2;
    test_reset_wait();
    sel = 2'd0;
    test_lat1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
